// File: rtl/slope_track.sv
// Streaming turning-point detector: tracks run direction with a hysteresis deadband
// and flags peaks/valleys with the extremum value and run length that led to them.
module slope_track #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] datain,
    input  logic [WIDTH-1:0] thresh,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataout,
    output logic             posen,
    output logic             negen,
    output logic [WIDTH-1:0] extval,
    output logic [CNT_W-1:0] runlen
);

    localparam int unsigned DW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_INIT,
        S_FLAT,
        S_RISE,
        S_FALL
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] ref_q, ref_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             pos_nx, neg_nx;
    logic [WIDTH-1:0] ext_nx;
    logic [CNT_W-1:0] run_nx;

    logic [DW-1:0]    x_ext, ref_ext, th_ext, up_diff, dn_diff;
    logic             up, down, ge, le;

    // One extra bit keeps both differences exact for either signedness.
    always_comb begin
        x_ext   = SIGNED ? {datain[WIDTH-1], datain} : {1'b0, datain};
        ref_ext = SIGNED ? {ref_q[WIDTH-1], ref_q}   : {1'b0, ref_q};
        th_ext  = {1'b0, thresh};
        up_diff = x_ext - ref_ext;
        dn_diff = ref_ext - x_ext;
        up      = $signed(up_diff) > $signed(th_ext);
        down    = $signed(dn_diff) > $signed(th_ext);
        ge      = ~up_diff[DW-1];
        le      = ~dn_diff[DW-1];
        cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    end

    // Next-state, reference, counter and pulse decisions for an accepted sample.
    always_comb begin
        state_nx = state;
        ref_nx   = ref_q;
        cnt_nx   = cnt;
        pos_nx   = 1'b0;
        neg_nx   = 1'b0;
        ext_nx   = extval;
        run_nx   = runlen;
        if (in_valid) begin
            unique case (state)
                S_INIT: begin
                    ref_nx   = datain;
                    state_nx = S_FLAT;
                end
                S_FLAT: begin
                    if (up) begin
                        state_nx = S_RISE;
                        ref_nx   = datain;
                        cnt_nx   = CNT_W'(1);
                    end else if (down) begin
                        state_nx = S_FALL;
                        ref_nx   = datain;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                S_RISE: begin
                    if (ge) begin
                        ref_nx = datain;
                        cnt_nx = cnt_inc;
                    end else if (down) begin
                        pos_nx   = 1'b1;
                        ext_nx   = ref_q;
                        run_nx   = cnt;
                        state_nx = S_FALL;
                        ref_nx   = datain;
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                S_FALL: begin
                    if (le) begin
                        ref_nx = datain;
                        cnt_nx = cnt_inc;
                    end else if (up) begin
                        neg_nx   = 1'b1;
                        ext_nx   = ref_q;
                        run_nx   = cnt;
                        state_nx = S_RISE;
                        ref_nx   = datain;
                        cnt_nx   = CNT_W'(1);
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: state_nx = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            ref_q     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            dataout   <= '0;
            posen     <= 1'b0;
            negen     <= 1'b0;
            extval    <= '0;
            runlen    <= '0;
        end else begin
            state     <= state_nx;
            ref_q     <= ref_nx;
            cnt       <= cnt_nx;
            out_valid <= in_valid;
            dataout   <= in_valid ? datain : dataout;
            posen     <= pos_nx;
            negen     <= neg_nx;
            extval    <= ext_nx;
            runlen    <= run_nx;
        end
    end

endmodule

// File: tb/tb_slope_track.sv
// Scoreboard bench for slope_track: directed samples push expected outputs,
// per-instance monitors pop and compare whenever out_valid is seen.
module tb_slope_track;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 16-bit unsigned, 4-bit counter (saturation visible)
    logic        a_rst, a_valid;
    logic [15:0] a_data, a_th;
    logic        a_ov, a_pos, a_neg;
    logic [15:0] a_dout, a_ext;
    logic [3:0]  a_run;

    // Instances B (signed) and C (unsigned): 8-bit, shared stimulus
    logic        b_rst, b_valid;
    logic [7:0]  b_data, b_th;
    logic        b_ov, b_pos, b_neg, c_ov, c_pos, c_neg;
    logic [7:0]  b_dout, b_ext, c_dout, c_ext;
    logic [7:0]  b_run, c_run;

    slope_track #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(4)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_valid), .datain(a_data), .thresh(a_th),
        .out_valid(a_ov), .dataout(a_dout), .posen(a_pos), .negen(a_neg),
        .extval(a_ext), .runlen(a_run));

    slope_track #(.WIDTH(8), .SIGNED(1'b1), .CNT_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .datain(b_data), .thresh(b_th),
        .out_valid(b_ov), .dataout(b_dout), .posen(b_pos), .negen(b_neg),
        .extval(b_ext), .runlen(b_run));

    slope_track #(.WIDTH(8), .SIGNED(1'b0), .CNT_W(8)) dut_c (
        .clk(clk), .rst(b_rst), .in_valid(b_valid), .datain(b_data), .thresh(b_th),
        .out_valid(c_ov), .dataout(c_dout), .posen(c_pos), .negen(c_neg),
        .extval(c_ext), .runlen(c_run));

    typedef struct {
        logic [15:0] d;
        logic        p;
        logic        n;
        logic [15:0] e;
        logic [7:0]  r;
    } exp_t;

    exp_t        q[3][$];
    logic [15:0] last_ext[3];
    logic [7:0]  last_run[3];
    int          errors = 0;
    int          checks = 0;
    bit          started = 1'b0;

    task automatic expect_out(input int i, input logic [15:0] x, input logic p, input logic n,
                              input logic [15:0] e, input logic [7:0] r);
        exp_t t;
        if (p || n) begin
            last_ext[i] = e;
            last_run[i] = r;
        end
        t.d = x; t.p = p; t.n = n; t.e = last_ext[i]; t.r = last_run[i];
        q[i].push_back(t);
    endtask

    task automatic mon(input int i, input string name, input logic ov, input logic p,
                       input logic n, input logic [15:0] d, input logic [15:0] e,
                       input logic [7:0] r);
        exp_t t;
        checks++;
        if (ov === 1'b1) begin
            if (q[i].size() == 0) begin
                errors++;
                $display("FAIL %s unexpected out_valid: got d=%h p=%b n=%b, expected none",
                         name, d, p, n);
            end else begin
                t = q[i].pop_front();
                if (d !== t.d || p !== t.p || n !== t.n || e !== t.e || r !== t.r) begin
                    errors++;
                    $display("FAIL %s output: got d=%h p=%b n=%b ext=%h run=%0d, expected d=%h p=%b n=%b ext=%h run=%0d",
                             name, d, p, n, e, r, t.d, t.p, t.n, t.e, t.r);
                end
            end
        end else if (p !== 1'b0 || n !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL %s bubble: got ov=%b p=%b n=%b, expected all 0", name, ov, p, n);
        end
    endtask

    always @(negedge clk) if (started) mon(0, "A", a_ov, a_pos, a_neg, a_dout, a_ext, 8'(a_run));
    always @(negedge clk) if (started) mon(1, "B", b_ov, b_pos, b_neg, 16'(b_dout), 16'(b_ext), b_run);
    always @(negedge clk) if (started) mon(2, "C", c_ov, c_pos, c_neg, 16'(c_dout), 16'(c_ext), c_run);

    task automatic check_zero_a(input string name);
        checks++;
        if (a_ov !== 1'b0 || a_pos !== 1'b0 || a_neg !== 1'b0 || a_dout !== 16'h0 ||
            a_ext !== 16'h0 || a_run !== 4'h0) begin
            errors++;
            $display("FAIL %s: got ov=%b p=%b n=%b d=%h ext=%h run=%0d, expected all 0",
                     name, a_ov, a_pos, a_neg, a_dout, a_ext, a_run);
        end
    endtask

    task automatic check_zero_bc(input string name);
        checks++;
        if ({b_ov, b_pos, b_neg, c_ov, c_pos, c_neg} !== 6'b0 ||
            {b_dout, b_ext, b_run, c_dout, c_ext, c_run} !== 48'h0) begin
            errors++;
            $display("FAIL %s: got B ov=%b d=%h ext=%h run=%0d C ov=%b d=%h ext=%h run=%0d, expected all 0",
                     name, b_ov, b_dout, b_ext, b_run, c_ov, c_dout, c_ext, c_run);
        end
    endtask

    task automatic send_a(input logic [15:0] x, input logic [15:0] th, input logic p,
                          input logic n, input logic [15:0] e, input logic [7:0] r);
        expect_out(0, x, p, n, e, r);
        a_valid = 1'b1; a_data = x; a_th = th;
        @(posedge clk); #1;
    endtask

    task automatic send_bc(input logic [7:0] x, input logic pb, input logic nb,
                           input logic [7:0] eb, input logic [7:0] rb, input logic pc,
                           input logic nc, input logic [7:0] ec, input logic [7:0] rc);
        expect_out(1, 16'(x), pb, nb, 16'(eb), rb);
        expect_out(2, 16'(x), pc, nc, 16'(ec), rc);
        b_valid = 1'b1; b_data = x; b_th = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One-cycle reset of A; outputs must be zero during and one cycle after.
    task automatic reset_a(input string name);
        a_rst = 1'b1; a_valid = 1'b0;
        @(posedge clk); #1;
        check_zero_a({name, " during reset"});
        a_rst = 1'b0;
        last_ext[0] = '0; last_run[0] = '0;
        @(posedge clk); #1;
        check_zero_a({name, " after reset"});
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; a_th = '0; b_data = '0; b_th = '0;
        for (int i = 0; i < 3; i++) begin last_ext[i] = '0; last_run[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        check_zero_a("A initial reset");
        check_zero_bc("BC initial reset");
        a_rst = 1'b0; b_rst = 1'b0;
        started = 1'b1;

        // Basic peak
        send_a(16'd1, 16'd0, 0, 0, 0, 0);
        send_a(16'd3, 16'd0, 0, 0, 0, 0);
        send_a(16'd5, 16'd0, 0, 0, 0, 0);
        send_a(16'd4, 16'd0, 1, 0, 16'd5, 8'd2);
        // Continue into a valley, then reset mid-rise discards the run
        send_a(16'd1, 16'd0, 0, 0, 0, 0);
        send_a(16'd3, 16'd0, 0, 1, 16'd1, 8'd2);
        send_a(16'd5, 16'd0, 0, 0, 0, 0);
        reset_a("A mid-run");
        send_a(16'd4, 16'd0, 0, 0, 0, 0);
        send_a(16'd2, 16'd0, 0, 0, 0, 0);
        send_a(16'd6, 16'd0, 0, 1, 16'd2, 8'd1);
        idle(1);

        // Hysteresis deadband
        reset_a("A pre-hysteresis");
        send_a(16'd10, 16'd2, 0, 0, 0, 0);
        send_a(16'd14, 16'd2, 0, 0, 0, 0);
        send_a(16'd13, 16'd2, 0, 0, 0, 0);
        send_a(16'd12, 16'd2, 0, 0, 0, 0);
        send_a(16'd11, 16'd2, 1, 0, 16'd14, 8'd3);
        send_a(16'd15, 16'd2, 0, 1, 16'd11, 8'd1);
        idle(1);

        // Basic peak with bubbles of 0..3 cycles
        reset_a("A pre-bubbles");
        send_a(16'd1, 16'd0, 0, 0, 0, 0);
        send_a(16'd3, 16'd0, 0, 0, 0, 0);
        idle(1);
        send_a(16'd5, 16'd0, 0, 0, 0, 0);
        idle(2);
        send_a(16'd4, 16'd0, 1, 0, 16'd5, 8'd2);
        idle(3);

        // Saturating run length
        reset_a("A pre-saturation");
        for (int v = 0; v < 20; v++) send_a(16'(v), 16'd0, 0, 0, 0, 0);
        send_a(16'd0, 16'd0, 1, 0, 16'd19, 8'd15);
        idle(1);

        // Full-scale swing just above a near-full-scale threshold
        reset_a("A pre-extremes");
        send_a(16'hFFFF, 16'hFFFE, 0, 0, 0, 0);
        send_a(16'h0000, 16'hFFFE, 0, 0, 0, 0);
        send_a(16'hFFFF, 16'hFFFE, 0, 1, 16'h0000, 8'd1);
        send_a(16'hFFFF, 16'hFFFF, 0, 0, 0, 0);
        send_a(16'h0000, 16'hFFFF, 0, 0, 0, 0);
        idle(2);

        // Signed vs unsigned interpretation of the same byte stream
        send_bc(8'h05, 0, 0, 0, 0,     0, 0, 0,     0);
        send_bc(8'hFE, 0, 0, 0, 0,     0, 0, 0,     0);
        send_bc(8'hF0, 0, 0, 0, 0,     1, 0, 8'hFE, 8'd1);
        send_bc(8'h03, 0, 1, 8'hF0, 8'd2, 0, 0, 0,  0);
        send_bc(8'h80, 1, 0, 8'h03, 8'd1, 0, 1, 8'h03, 8'd2);
        idle(3);

        for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[i].size() != 0) begin
                errors++;
                $display("FAIL drain %0d: got %0d outputs missing, expected 0", i, q[i].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
